data_cache: RTL
===============

// Module: data_cache
// PURPOSE
//   Direct-mapped, write-through, no-write-allocate L1 data cache between the RISC-V core's
//   data port (ALUResult/WriteData/MemWrite/MemRead in, ReadData/stall out) and word-wide
//   main memory. Read hits return data in the same cycle with no stall. Misses and all
//   stores raise stall until the memory transaction completes.
// PARAMETERS
//   LINES     16  number of cache lines; power of 2
//   WORDS     4   32-bit words per line; power of 2, >=2
//   ADDR_W    32  byte-address width
// PORTS
//   clock      in   1   single clock; all state updates on rising edge
//   reset      in   1   synchronous, active-high
//   Addr       in   32  core byte address (ALUResult); bits[1:0] ignored, word accesses only
//   WriteData  in   32  core store data
//   MemRead    in   1   core load request, level, held while stall=1
//   MemWrite   in   1   core store request, level, held while stall=1
//   ReadData   out  32  load data; valid when MemRead=1 and stall=0
//   stall      out  1   freeze core (combinational)
//   mem_req    out  1   memory request, registered
//   mem_we     out  1   1=write, 0=read; valid with mem_req
//   mem_addr   out  32  word-aligned memory byte address
//   mem_wdata  out  32  memory write data
//   mem_rdata  in   32  memory read data; valid when mem_ready=1
//   mem_ready  in   1   one beat completes in each cycle where mem_req and mem_ready are both 1
//   hit_count  out  32  load hits, saturating at 0xFFFFFFFF
//   miss_count out  32  load misses, saturating at 0xFFFFFFFF
// BEHAVIOUR
//   Address split: off = Addr[2+:log2(WORDS)], idx = the next log2(LINES) bits, tag = the rest.
//     Defaults: off = [3:2], idx = [7:4], tag = [31:8].
//   Storage: valid[LINES], tag[LINES], data[LINES][WORDS].
//   hit = valid[idx] && tag[idx] == Addr tag.
//   FSM states: IDLE, REFILL, WRITE.
//   IDLE:
//     - MemWrite=1 (priority over MemRead): stall=1; latch addr/data; go to WRITE.
//     - MemRead=1 and hit: stall=0; ReadData = data[idx][off] combinationally; hit_count++.
//     - MemRead=1 and miss: stall=1; miss_count++; beat counter=0; go to REFILL.
//     - Otherwise: stall=0.
//   REFILL:
//     - stall=1.
//     - mem_req=1, mem_we=0, mem_addr = {tag, idx, beat, 2'b00}; beats issued in order 0..WORDS-1.
//     - On each ready: data[idx][beat] <= mem_rdata; beat++.
//     - On the last ready: valid <= 1; tag <= new tag; go to IDLE.
//     - The held load then hits in IDLE and is not recounted as a miss or a hit.
//   WRITE:
//     - mem_req=1, mem_we=1, mem_addr = latched word address, mem_wdata = latched data.
//     - stall = !mem_ready, so the store retires in the ready cycle.
//     - On ready: if the line hits, update that word in the cache (no allocate on miss); go to IDLE.
//   Latency (memory ready delay L cycles per beat):
//     - Read hit: 0 cycles.
//     - Read miss: 1 + WORDS*(L+1) stall cycles, then the hit cycle.
//     - Store: 1 + L stall cycles; minimum 1 with L=0.
//   mem_addr and mem_we are stable while mem_req=1 and ready=0. mem_req=0 in IDLE.
//   Request changes while stall=1 are ignored; the latched values are used.
//   Reset (any state, including mid-REFILL/WRITE), on the edge where reset=1:
//     - All valid bits cleared, state=IDLE, beat=0, mem_req=0, mem_we=0.
//     - Counters=0, ReadData=0, stall=0 while reset=1.
//     - A partial refill leaves its line invalid.
//   Counters saturate at the maximum value and never wrap.
// TESTING
//   1. Cold load 0x100, L=2, mem[0x100..0x10C]=A,B,C,D ->
//      mem_addr 0x100,0x104,0x108,0x10C in order; stall=1 for 13 cycles;
//      then ReadData=A, stall=0; miss_count=1.
//   2. After 1, load 0x108 -> same-cycle ReadData=C, stall=0, no mem_req; hit_count=1.
//   3. Store 0x104=0xDEAD (hit), L=1 -> one write beat to 0x104; stall=1 for 2 cycles;
//      later load 0x104 hits with 0xDEAD.
//   4. Store 0x2F0 (miss) -> memory write only; next load 0x2F0 misses and refills 0x2F0..0x2FC.
//   5. Conflict: load 0x100 then load 0x500 (same idx 0, different tag) -> 0x500 refills line 0;
//      reload 0x100 misses; miss_count=3.
//   6. Reset asserted during beat 2 of a refill -> next cycle mem_req=0 and stall=0;
//      a reload of the same address performs a full 4-beat refill. Also assert MemRead=1 and
//      MemWrite=1 together -> a write is performed.

Source files
------------

// File: rtl/data_cache_if.sv
// Core data port plus word-wide memory port of the L1 data cache.
// master = core/memory side, slave = the cache itself.
interface data_cache_if #(parameter int ADDR_W = 32);
   logic [ADDR_W-1:0] Addr;
   logic [31:0]       WriteData;
   logic              MemRead;
   logic              MemWrite;
   logic [31:0]       ReadData;
   logic              stall;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ready;
   logic [31:0]       hit_count;
   logic [31:0]       miss_count;

   modport master (
      output Addr, WriteData, MemRead, MemWrite, mem_rdata, mem_ready,
      input  ReadData, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
   );
   modport slave (
      input  Addr, WriteData, MemRead, MemWrite, mem_rdata, mem_ready,
      output ReadData, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
   );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Read hits complete combinationally; misses refill a full line, stores go straight to memory.
module data_cache #(
   parameter int LINES  = 16,
   parameter int WORDS  = 4,
   parameter int ADDR_W = 32
) (
   input logic          clock,
   input logic          reset,
   data_cache_if.slave  bus
);
   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
   state_t state, state_n;

   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tags   [LINES];
   logic [31:0]       data_q [LINES][WORDS];

   logic [OFF_W-1:0]  beat, beat_nx;
   logic [ADDR_W-3:0] lat_wa;
   logic              req_q, we_q;
   logic [ADDR_W-1:0] maddr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       hits_q, misses_q;
   logic              just_filled;

   logic [OFF_W-1:0]  off, l_off;
   logic [IDX_W-1:0]  idx, l_idx;
   logic [TAG_W-1:0]  tag, l_tag;
   logic              hit, l_hit, beat_done, last_beat;
   logic              cnt_hit, cnt_miss;
   logic [31:0]       rdata;
   logic              stall_c;

   assign off   = bus.Addr[2 +: OFF_W];
   assign idx   = bus.Addr[2 + OFF_W +: IDX_W];
   assign tag   = bus.Addr[ADDR_W-1 -: TAG_W];
   assign l_off = lat_wa[0 +: OFF_W];
   assign l_idx = lat_wa[OFF_W +: IDX_W];
   assign l_tag = lat_wa[ADDR_W-3 -: TAG_W];

   assign hit       = valid[idx] && (tags[idx] == tag);
   assign l_hit     = valid[l_idx] && (tags[l_idx] == l_tag);
   assign beat_done = req_q && bus.mem_ready;
   assign last_beat = (beat == OFF_W'(WORDS-1));
   assign beat_nx   = beat + OFF_W'(1);

   always_comb begin
      state_n  = state;
      stall_c  = 1'b0;
      rdata    = '0;
      cnt_hit  = 1'b0;
      cnt_miss = 1'b0;
      case (state)
         IDLE: begin
            if (bus.MemWrite) begin
               stall_c = 1'b1;
               state_n = WRITE;
            end else if (bus.MemRead) begin
               if (hit) begin
                  rdata   = data_q[idx][off];
                  // the replayed load after a refill was already counted as a miss
                  cnt_hit = !just_filled;
               end else begin
                  stall_c  = 1'b1;
                  cnt_miss = 1'b1;
                  state_n  = REFILL;
               end
            end
         end
         REFILL: begin
            stall_c = 1'b1;
            if (beat_done && last_beat) state_n = IDLE;
         end
         WRITE: begin
            stall_c = !bus.mem_ready;
            if (bus.mem_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (reset) begin
         stall_c = 1'b0;
         rdata   = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         valid       <= '0;
         beat        <= '0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         hits_q      <= '0;
         misses_q    <= '0;
         just_filled <= 1'b0;
      end else begin
         state       <= state_n;
         just_filled <= 1'b0;
         if (cnt_hit && hits_q != '1)    hits_q   <= hits_q + 32'd1;
         if (cnt_miss && misses_q != '1) misses_q <= misses_q + 32'd1;
         case (state)
            IDLE: begin
               if (state_n == WRITE) begin
                  lat_wa  <= bus.Addr[ADDR_W-1:2];
                  req_q   <= 1'b1;
                  we_q    <= 1'b1;
                  maddr_q <= {bus.Addr[ADDR_W-1:2], 2'b00};
                  wdata_q <= bus.WriteData;
               end else if (state_n == REFILL) begin
                  lat_wa  <= bus.Addr[ADDR_W-1:2];
                  beat    <= '0;
                  req_q   <= 1'b1;
                  we_q    <= 1'b0;
                  maddr_q <= {bus.Addr[ADDR_W-1:2+OFF_W], {OFF_W{1'b0}}, 2'b00};
               end
            end
            REFILL: begin
               if (beat_done) begin
                  if (last_beat) begin
                     valid[l_idx] <= 1'b1;
                     tags[l_idx]  <= l_tag;
                     req_q        <= 1'b0;
                     beat         <= '0;
                     just_filled  <= 1'b1;
                  end else begin
                     beat    <= beat_nx;
                     maddr_q <= {lat_wa[ADDR_W-3:OFF_W], beat_nx, 2'b00};
                  end
               end
            end
            WRITE: begin
               if (beat_done) begin
                  req_q <= 1'b0;
                  we_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // line storage has no reset; validity alone decides whether it is usable
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state == REFILL && beat_done) data_q[l_idx][beat] <= bus.mem_rdata;
         if (state == WRITE && beat_done && l_hit) data_q[l_idx][l_off] <= wdata_q;
      end
   end

   assign bus.ReadData   = rdata;
   assign bus.stall      = stall_c;
   assign bus.mem_req    = req_q;
   assign bus.mem_we     = we_q;
   assign bus.mem_addr   = maddr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.hit_count  = hits_q;
   assign bus.miss_count = misses_q;
endmodule
